// File: rtl/dct.sv
// rtl/dct.sv - frame DCT-II of mel energies, one MAC per cycle with saturated cepstral outputs.
// Optional macro DCT_SKIP_C0_EN shifts the cosine row index by one to drop c0.
module dct #(
    parameter int NUM_CEPS    = 12,
    parameter int NUM_FILTERS = 40,
    parameter int INPUT_WIDTH = 8,
    parameter int CEPS_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [$clog2(NUM_FILTERS)-1:0]  frame_ptr_i,
    input  logic [INPUT_WIDTH-1:0]          power_in,
    input  logic                            start_i,
    output logic                            dct_valid_o,
    output logic signed [CEPS_WIDTH-1:0]    ceps_out,
    output logic [$clog2(NUM_CEPS)-1:0]     ceps_ptr_o,
    output logic                            dct_done_o
);
    localparam int NW       = $clog2(NUM_FILTERS);
    localparam int KW       = $clog2(NUM_CEPS);
    localparam int ACC_W    = 32;
    localparam int COEF_W   = 16;
    localparam int PROD_W   = INPUT_WIDTH + 1 + COEF_W;
    localparam int FRAC     = 14;
    localparam int CEPS_MAX = (1 << (CEPS_WIDTH - 1)) - 1;
    localparam int CEPS_MIN = -(1 << (CEPS_WIDTH - 1));
    localparam real PI      = 3.14159265358979323846;
`ifdef DCT_SKIP_C0_EN
    localparam int COS_OFS  = 1;
`else
    localparam int COS_OFS  = 0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [KW-1:0]              k;
    logic [NW-1:0]              n;
    logic signed [ACC_W-1:0]    acc;
    logic [INPUT_WIDTH-1:0]     x_buf [NUM_FILTERS];
    logic signed [COEF_W-1:0]   rom   [NUM_CEPS][NUM_FILTERS];
    logic signed [COEF_W-1:0]   coef;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [CEPS_WIDTH-1:0] sat_val;
    logic                       last_n;
    logic                       last_k;
    logic                       buf_wr;

    // Q1.14 cosine table, rounded half away from zero, folded at elaboration.
    for (genvar gk = 0; gk < NUM_CEPS; gk++) begin : g_rom_k
        for (genvar gn = 0; gn < NUM_FILTERS; gn++) begin : g_rom_n
            localparam real ANG = PI * real'(gk + COS_OFS) * (real'(gn) + 0.5) / real'(NUM_FILTERS);
            localparam real SCL = 16384.0 * $cos(ANG);
            localparam int  CV  = $rtoi((SCL >= 0.0) ? (SCL + 0.5) : (SCL - 0.5));
            assign rom[gk][gn] = COEF_W'(CV);
        end
    end

    assign last_n = (n == NW'(NUM_FILTERS - 1));
    assign last_k = (k == KW'(NUM_CEPS - 1));
    assign buf_wr = (state == IDLE) && in_valid && (int'(frame_ptr_i) < NUM_FILTERS);
    assign coef   = rom[k][n];
    assign prod   = PROD_W'($signed({1'b0, x_buf[n]})) * PROD_W'(coef);

    always_comb begin
        shifted = acc >>> FRAC;
        sat_val = CEPS_WIDTH'(shifted);
        if (shifted > CEPS_MAX) begin
            sat_val = CEPS_WIDTH'(CEPS_MAX);
        end else if (shifted < CEPS_MIN) begin
            sat_val = CEPS_WIDTH'(CEPS_MIN);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = COMPUTE;
            COMPUTE: if (last_n)  state_nxt = OUTPUT;
            OUTPUT:  state_nxt = last_k ? DONE : COMPUTE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                x_buf[i] <= '0;
            end
        end else if (buf_wr) begin
            x_buf[frame_ptr_i] <= power_in;
        end
    end

    // Outputs are registered, so each result appears one cycle after its OUTPUT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k           <= '0;
            n           <= '0;
            acc         <= '0;
            dct_valid_o <= 1'b0;
            dct_done_o  <= 1'b0;
            ceps_out    <= '0;
            ceps_ptr_o  <= '0;
        end else begin
            dct_valid_o <= 1'b0;
            dct_done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        k   <= '0;
                        n   <= '0;
                        acc <= '0;
                    end
                end
                COMPUTE: begin
                    acc <= acc + ACC_W'(prod);
                    n   <= last_n ? '0 : n + NW'(1);
                end
                OUTPUT: begin
                    dct_valid_o <= 1'b1;
                    ceps_out    <= sat_val;
                    ceps_ptr_o  <= k;
                    acc         <= '0;
                    k           <= last_k ? '0 : k + KW'(1);
                end
                DONE: begin
                    dct_done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dct.sv
// tb/tb_dct.sv - scoreboard bench for dct: directed frames, latency, re-start, busy writes, mid-transform reset.
module tb_dct;
    localparam int NC = 12;
    localparam int NF = 40;
    localparam real PI = 3.14159265358979323846;
`ifdef DCT_SKIP_C0_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [5:0]        frame_ptr_i = '0;
    logic [7:0]        power_in = '0;
    logic              start_i = 1'b0;
    logic              dct_valid_o;
    logic signed [15:0] ceps_out;
    logic [3:0]        ceps_ptr_o;
    logic              dct_done_o;

    dct dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .frame_ptr_i (frame_ptr_i),
        .power_in    (power_in),
        .start_i     (start_i),
        .dct_valid_o (dct_valid_o),
        .ceps_out    (ceps_out),
        .ceps_ptr_o  (ceps_ptr_o),
        .dct_done_o  (dct_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ptr;
        int lo;
        int hi;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   x_m [NF];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=[%0d,%0d] cycle=%0d", name, act, lo, hi, cyc);
        end
    endtask

    function automatic int rom_m(input int kk, input int nn);
        real a;
        a = 16384.0 * $cos(PI * real'(kk) * (real'(nn) + 0.5) / real'(NF));
        return $rtoi((a >= 0.0) ? (a + 0.5) : (a - 0.5));
    endfunction

    function automatic int model(input int k);
        longint acc = 0;
        for (int i = 0; i < NF; i++) acc += longint'(x_m[i]) * longint'(rom_m(k + OFS, i));
        acc = acc >>> 14;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    // Monitor: every valid/done must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dct_valid_o && dct_done_o) check("valid_done_overlap", 1, 0, 0);
            if (dct_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", int'(ceps_ptr_o), -1, -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ceps_ptr", int'(ceps_ptr_o), e.ptr, e.ptr);
                    check($sformatf("ceps_out_k%0d", e.ptr), int'(ceps_out), e.lo, e.hi);
                    check($sformatf("valid_latency_k%0d", e.ptr), cyc - start_cyc, e.lat, e.lat);
                end
            end
            if (dct_done_o) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", cyc - start_cyc, -1, -1);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    check("done_latency", cyc - start_cyc, d, d);
                end
            end
        end
    end

    task automatic write(input int idx, input int val);
        @(negedge clk);
        in_valid    = 1'b1;
        frame_ptr_i = 6'(idx);
        power_in    = 8'(val);
        if (idx < NF) x_m[idx] = val;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input int v0, input int vrest);
        for (int i = 0; i < NF; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            frame_ptr_i = 6'(i);
            power_in    = 8'((i == 0) ? v0 : vrest);
            x_m[i]      = (i == 0) ? v0 : vrest;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode 0: model; mode 1: flat frame (k0 = h0, others within +/-1); mode 2: k0/k1 = h0/h1.
    task automatic go(input int mode, input int h0, input int h1);
        for (int k = 0; k < NC; k++) begin
            exp_t e;
            e.ptr = k;
            e.lo  = model(k);
            e.hi  = e.lo;
            e.lat = 41 * (k + 1);
`ifndef DCT_SKIP_C0_EN
            if (mode == 1) begin
                e.lo = (k == 0) ? h0 : -1;
                e.hi = (k == 0) ? h0 : 1;
            end
            if (mode == 2 && k < 2) begin
                e.lo = (k == 0) ? h0 : h1;
                e.hi = e.lo;
            end
`else
            if (mode == 1) begin
                e.lo = -1;
                e.hi = 1;
            end
`endif
            exp_q.push_back(e);
        end
        done_q.push_back(41 * NC + 1);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < 700) begin
            @(posedge clk);
            t++;
        end
        check("transform_timeout", t, 0, 699);
        if (t >= 700) begin
            exp_q.delete();
            done_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, int'(dct_valid_o), 0, 0);
        check({tag, "_done"}, int'(dct_done_o), 0, 0);
        check({tag, "_ceps_out"}, int'(ceps_out), 0, 0);
        check({tag, "_ceps_ptr"}, int'(ceps_ptr_o), 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NF; i++) x_m[i] = 0;
        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        load(10, 10);
        go(1, 400, 0);
        wait_done();

        load(255, 255);
        go(1, 10200, 0);
        wait_done();

        load(100, 0);
        go(2, 100, 99);
        wait_done();

        // Re-start pulse and buffer write while busy must both be ignored.
        go(2, 100, 99);
        repeat (98) @(posedge clk);
        @(negedge clk);
        start_i     = 1'b1;
        in_valid    = 1'b1;
        frame_ptr_i = 6'd1;
        power_in    = 8'd200;
        @(negedge clk);
        start_i  = 1'b0;
        in_valid = 1'b0;
        wait_done();

        write(40, 77);
        write(63, 77);
        go(2, 100, 99);
        wait_done();

        load(3, 250);
        go(0, 0, 0);
        wait_done();

        // Abort mid-transform: outputs clear, nothing further emerges.
        go(0, 0, 0);
        repeat (199) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < NF; i++) x_m[i] = 0;
        #1 check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check_zero_outputs("post_abort");

        go(0, 0, 0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
